// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the bit-serial two's-complement negator.
//   lane_state_t : per-lane framing state (IDLE waits for start-of-frame,
//                  ACTIVE is collecting the remaining bits of a word)
//   DEF_WIDTH    : default bits per serial word
//   DEF_CHANNELS : default number of independent lanes
//   CNT_W        : bit-counter width for the default word size
//   slice_lsb()  : LSB position of a lane's word inside a packed lane vector
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } lane_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int CNT_W        = $clog2(DEF_WIDTH);

    // Lane k occupies [k*width +: width] of a packed multi-lane word bus.
    function automatic int slice_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/serial_negate_lane.sv
// -----------------------------------------------------------------------------
// serial_negate_lane
// One channel of the bit-serial, LSB-first two's-complement negator.
// Copies bits up to and including the first '1' of a word, then inverts the
// rest (negate mode) or passes every bit unchanged (pass mode). Also rebuilds
// the processed word in parallel and flags the one value that cannot be
// negated (the most negative number).
//
// Ports
//   clk_i        : rising-edge clock
//   rst_i        : synchronous active-high reset
//   valid_i      : bit_i / sof_i / neg_en_i are valid this cycle
//   bit_i        : serial input bit, LSB first
//   sof_i        : marks bit 0 of a word (qualified by valid_i)
//   neg_en_i     : sampled with sof_i; 1 = negate, 0 = pass through
//   out_valid_o  : registered; out_bit_o is valid
//   out_bit_o    : processed serial bit, one cycle after its input bit
//   word_valid_o : one-cycle pulse with the last out_valid_o of a word
//   word_data_o  : processed word, held until the next word_valid_o
//   ovf_o        : pulses with word_valid_o when negating 1<<(WIDTH-1)
//
// Handshake: there is no backpressure. A bit is consumed in any cycle where
// valid_i is high; cycles with valid_i low leave all lane state untouched and
// produce out_valid_o = 0 on the following cycle.
// -----------------------------------------------------------------------------
module serial_negate_lane
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             bit_i,
    input  logic             sof_i,
    input  logic             neg_en_i,
    output logic             out_valid_o,
    output logic             out_bit_o,
    output logic             word_valid_o,
    output logic [WIDTH-1:0] word_data_o,
    output logic             ovf_o
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    lane_state_t      state_q;
    logic [CW-1:0]    cnt_q;
    logic             seen_q;   // a '1' has already been consumed in this word
    logic             mode_q;   // 1 = negate current word
    logic [WIDTH-1:0] shreg_q;  // processed bits, shifted in at the MSB end

    logic             start_bit;
    logic             cont_bit;
    logic             proc_bit_d;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        // A start-of-frame always begins a new word, even mid-word (abort).
        start_bit  = valid_i && sof_i;
        cont_bit   = valid_i && !sof_i && (state_q == ACTIVE);
        // At start-of-frame seen_one is cleared, so bit 0 always passes through.
        proc_bit_d = start_bit ? bit_i
                               : ((mode_q && seen_q) ? ~bit_i : bit_i);
        // After WIDTH shifts, bit 0 of the word lands at index 0, so stale
        // bits from an aborted word are always pushed out by a complete word.
        shreg_d    = {proc_bit_d, shreg_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            mode_q       <= 1'b0;
            shreg_q      <= '0;
            out_valid_o  <= 1'b0;
            out_bit_o    <= 1'b0;
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
            ovf_o        <= 1'b0;
        end else begin
            out_valid_o  <= 1'b0;
            word_valid_o <= 1'b0;
            ovf_o        <= 1'b0;

            if (start_bit) begin
                state_q     <= ACTIVE;
                cnt_q       <= CW'(1);
                seen_q      <= bit_i;
                mode_q      <= neg_en_i;
                shreg_q     <= shreg_d;
                out_valid_o <= 1'b1;
                out_bit_o   <= proc_bit_d;
            end else if (cont_bit) begin
                seen_q      <= seen_q | bit_i;
                shreg_q     <= shreg_d;
                out_valid_o <= 1'b1;
                out_bit_o   <= proc_bit_d;
                if (cnt_q == LAST_CNT) begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    word_valid_o <= 1'b1;
                    word_data_o  <= shreg_d;
                    // Only 1<<(WIDTH-1) reaches its MSB with no earlier '1'.
                    ovf_o        <= mode_q & bit_i & ~seen_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            // Invalid bits in IDLE and idle cycles leave the lane untouched.
        end
    end

endmodule

// File: rtl/serial_twos_comp_nch.sv
// -----------------------------------------------------------------------------
// serial_twos_comp_nch
// Multi-channel bit-serial two's-complement negator. Instantiates CHANNELS
// fully independent serial_negate_lane instances and packs their outputs.
//
// Ports (bit k / slice k belongs to lane k)
//   clk        : rising-edge clock
//   r          : synchronous active-high reset
//   in_valid   : in_bit[k] valid this cycle
//   in_bit     : serial data, LSB first
//   in_sof     : start-of-frame, marks bit 0 of a word
//   neg_en     : sampled with in_sof; 1 = negate, 0 = pass
//   out_valid  : registered output-bit valid
//   out_bit    : processed serial bit
//   word_valid : one-cycle word-complete pulse
//   word_data  : lane k word at [k*WIDTH +: WIDTH]
//   ovf        : negate-overflow pulse, aligned with word_valid
// -----------------------------------------------------------------------------
module serial_twos_comp_nch
    import serial_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      r,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_bit,
    input  logic [CHANNELS-1:0]       in_sof,
    input  logic [CHANNELS-1:0]       neg_en,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS-1:0]       out_bit,
    output logic [CHANNELS-1:0]       word_valid,
    output logic [CHANNELS*WIDTH-1:0] word_data,
    output logic [CHANNELS-1:0]       ovf
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        localparam int LSB = slice_lsb(k, WIDTH);

        serial_negate_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk_i       (clk),
            .rst_i       (r),
            .valid_i     (in_valid[k]),
            .bit_i       (in_bit[k]),
            .sof_i       (in_sof[k]),
            .neg_en_i    (neg_en[k]),
            .out_valid_o (out_valid[k]),
            .out_bit_o   (out_bit[k]),
            .word_valid_o(word_valid[k]),
            .word_data_o (word_data[LSB +: WIDTH]),
            .ovf_o       (ovf[k])
        );
    end

endmodule

// File: tb/tb_serial_twos_comp_nch.sv
module tb_serial_twos_comp_nch;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            r;
    logic [CH-1:0]   in_valid, in_bit, in_sof, neg_en;
    logic [CH-1:0]   out_valid, out_bit, word_valid, ovf;
    logic [CH*W-1:0] word_data;

    serial_twos_comp_nch #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_sof    (in_sof),
        .neg_en    (neg_en),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .word_valid(word_valid),
        .word_data (word_data),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus plan and expectations ----------------
    typedef struct packed {
        logic v;  // in_valid
        logic b;  // in_bit
        logic s;  // in_sof
        logic n;  // neg_en
        logic o;  // this item must produce an output bit
        logic e;  // expected output bit
    } item_t;

    typedef struct packed {
        int   cyc;
        logic e;
    } exp_bit_t;

    item_t      plan_q[CH][$];
    exp_bit_t   exp_q[CH][$];
    logic [W:0] exp_word_q[CH][$];   // {ovf, word}
    bit         lane_idle[CH];
    int         out_cnt[CH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: negation is (2^W - x) mod 2^W; pass mode is identity.
    function automatic logic [W-1:0] model_result(input logic [W-1:0] data, input logic neg);
        int v;
        v = int'(data);
        if (neg) v = ((1 << W) - v) % (1 << W);
        return W'(v);
    endfunction

    // Queue nbits bits of a word (nbits < W means the word is aborted by the
    // next start-of-frame). Output bit j of the processed stream equals bit j
    // of the result word, since the low bits of -x depend only on low bits of x.
    task automatic add_word(input int k, input logic [W-1:0] data, input logic neg,
                            input int nbits, input int gmin, input int gmax);
        logic [W-1:0] res;
        item_t        it;
        res = model_result(data, neg);
        for (int j = 0; j < nbits; j++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                it   = '0;
                it.b = 1'($urandom);
                it.n = 1'($urandom);
                plan_q[k].push_back(it);
            end
            it.v = 1'b1;
            it.b = data[j];
            it.s = (j == 0);
            it.n = (j == 0) ? neg : 1'($urandom);
            it.o = 1'b1;
            it.e = res[j];
            plan_q[k].push_back(it);
        end
        if (nbits == W) begin
            exp_word_q[k].push_back({neg && (data == W'(1 << (W - 1))), res});
            lane_idle[k] = 1'b1;
        end else begin
            lane_idle[k] = 1'b0;
        end
    endtask

    // Valid bits without sof while idle must be ignored entirely.
    task automatic add_junk(input int k, input int n);
        item_t it;
        if (lane_idle[k]) begin
            for (int j = 0; j < n; j++) begin
                it   = '0;
                it.v = 1'b1;
                it.b = 1'($urandom);
                it.n = 1'($urandom);
                plan_q[k].push_back(it);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_plans();
        int  guard;
        bit  busy;
        item_t it;
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 20000) begin
            busy = 1'b0;
            for (int k = 0; k < CH; k++) begin
                if (plan_q[k].size() > 0) begin
                    it = plan_q[k].pop_front();
                    busy = 1'b1;
                    if (it.o) exp_q[k].push_back({cyc, it.e});
                end else begin
                    it = '0;
                end
                in_valid[k] = it.v;
                in_bit[k]   = it.b;
                in_sof[k]   = it.s;
                neg_en[k]   = it.n;
            end
            if (busy) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        if (guard >= 20000) check("plan_timeout", 1, 0);
        in_valid = '0;
        in_sof   = '0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        exp_bit_t   x;
        logic [W:0] w;
        for (int k = 0; k < CH; k++) begin
            if (out_valid[k]) begin
                out_cnt[k]++;
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexp_out_l%0d", k), 1, 0);
                end else begin
                    x = exp_q[k].pop_front();
                    check($sformatf("out_bit_l%0d", k), 32'(out_bit[k]), 32'(x.e));
                    check($sformatf("out_lat_l%0d", k), 32'(cyc - x.cyc), 1);
                end
            end
            if (word_valid[k]) begin
                if (exp_word_q[k].size() == 0) begin
                    check($sformatf("unexp_word_l%0d", k), 1, 0);
                end else begin
                    w = exp_word_q[k].pop_front();
                    check($sformatf("word_data_l%0d", k), 32'(word_data[k*W +: W]), 32'(w[W-1:0]));
                    check($sformatf("ovf_l%0d", k), 32'(ovf[k]), 32'(w[W]));
                end
            end else if (ovf[k]) begin
                check($sformatf("ovf_stray_l%0d", k), 1, 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"},  32'(out_valid), 0);
        check({tag, "_out_bit"},    32'(out_bit), 0);
        check({tag, "_word_valid"}, 32'(word_valid), 0);
        check({tag, "_word_data"},  word_data, 0);
        check({tag, "_ovf"},        32'(ovf), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int sel;
        logic [W-1:0] d;
        logic [W-1:0] specials [5];
        specials[0] = 8'h80; specials[1] = 8'h00; specials[2] = 8'hFF;
        specials[3] = 8'h01; specials[4] = 8'h7F;

        for (int k = 0; k < CH; k++) begin
            lane_idle[k] = 1'b1;
            out_cnt[k]   = 0;
        end
        r = 1'b1;
        in_valid = '0; in_bit = '0; in_sof = '0; neg_en = '0;
        repeat (3) begin @(posedge clk); #1; end
        check_all_zero("reset");
        r = 1'b0;

        // Negate 0x06 on lane 0 -> 0xFA
        add_word(0, 8'h06, 1'b1, W, 0, 0);
        run_plans();

        // Boundary values and pass mode, with idle junk on another lane
        add_word(0, 8'h80, 1'b1, W, 0, 0);
        add_word(0, 8'h00, 1'b1, W, 0, 0);
        add_word(0, 8'h35, 1'b0, W, 0, 0);
        add_junk(2, 5);
        run_plans();

        // Negate 0x01 with 3 idle cycles between bits: exactly 8 out pulses
        base = out_cnt[0];
        add_word(0, 8'h01, 1'b1, W, 3, 3);
        run_plans();
        check("gap_pulses", 32'(out_cnt[0] - base), 8);

        // Lane 1 aborted at bit 4, then 0x02; other lanes run concurrently
        add_word(1, 8'h5B, 1'b1, 4, 0, 0);
        add_word(1, 8'h02, 1'b1, W, 0, 0);
        add_word(0, 8'h7F, 1'b1, W, 0, 0);
        add_word(2, 8'h01, 1'b1, W, 0, 0);
        add_word(3, 8'h10, 1'b1, W, 0, 0);
        run_plans();

        // Reset arriving with bit 5 of a word
        add_word(0, 8'hA6, 1'b1, 5, 0, 0);
        run_plans();
        r           = 1'b1;
        in_valid[0] = 1'b1;
        in_bit[0]   = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midword_reset");
        r        = 1'b0;
        in_valid = '0;
        for (int k = 0; k < CH; k++) lane_idle[k] = 1'b1;
        add_junk(0, 3);
        add_word(0, 8'h2C, 1'b1, W, 0, 1);
        run_plans();

        // Randomized traffic on all lanes
        for (int it = 0; it < 120; it++) begin
            for (int k = 0; k < CH; k++) begin
                sel = $urandom_range(9, 0);
                d = (sel < 2) ? specials[$urandom_range(4, 0)] : W'($urandom);
                if (sel == 9) begin
                    add_word(k, d, 1'($urandom), $urandom_range(W - 1, 1), 0, 2);
                end else begin
                    if ($urandom_range(3, 0) == 0) add_junk(k, $urandom_range(3, 1));
                    add_word(k, d, 1'($urandom), W, 0, 2);
                end
            end
            if (it % 10 == 9) run_plans();
        end
        for (int k = 0; k < CH; k++) add_word(k, W'($urandom), 1'b1, W, 0, 1);
        run_plans();

        for (int k = 0; k < CH; k++) begin
            check($sformatf("left_bits_l%0d", k), 32'(exp_q[k].size()), 0);
            check($sformatf("left_words_l%0d", k), 32'(exp_word_q[k].size()), 0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
